// File: rtl/ro_freq_counter.sv
// Multi-channel ring-oscillator frequency counter.
// Gated edge counting, latched result bank, serial readout.
module ro_freq_counter #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int GATE_W      = 16,
  parameter int SYNC_STAGES = 2,
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ro_in,
  input  logic              start,
  input  logic              mode,
  input  logic [GATE_W-1:0] gate_len,
  input  logic [SEL_W-1:0]  ch_sel,
  input  logic              load,
  input  logic              shift,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  result,
  output logic              overflow,
  output logic              sout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    GATE  = 2'd2,
    LATCH = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] prev;
  logic [NUM_CH-1:0] rise;

  logic [GATE_W-1:0] gate_cnt;
  logic              last_gate;

  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [NUM_CH-1:0] cnt_ovf;
  logic [CNT_W-1:0]  lat_cnt [NUM_CH];
  logic [NUM_CH-1:0] lat_ovf;

  logic [CNT_W-1:0]  sreg;

  // Synchronise ro_in and keep previous value for edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      prev <= '0;
    end else begin
      sync_q[0] <= ro_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev;

  assign last_gate = (gate_cnt == GATE_W'(1));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = ARM;
      end
      ARM: begin
        if (gate_len == '0) state_nxt = LATCH;
        else                state_nxt = GATE;
      end
      GATE: begin
        if (last_gate) state_nxt = LATCH;
      end
      LATCH: begin
        if (mode) state_nxt = ARM;
        else      state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state != IDLE);
  end

  // done pulses in the cycle after LATCH
  always_ff @(posedge clk) begin
    if (rst) begin
      done <= 1'b0;
    end else begin
      done <= (state == LATCH);
    end
  end

  // Gate window down-counter
  always_ff @(posedge clk) begin
    if (rst) begin
      gate_cnt <= '0;
    end else if (state == ARM) begin
      gate_cnt <= gate_len;
    end else if (state == GATE) begin
      gate_cnt <= gate_cnt - GATE_W'(1);
    end
  end

  // Live saturating edge counters
  always_ff @(posedge clk) begin
    if (rst || state == ARM) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt[c] <= '0;
      end
      cnt_ovf <= '0;
    end else if (state == GATE) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (rise[c]) begin
          if (&cnt[c]) cnt_ovf[c] <= 1'b1;
          else         cnt[c] <= cnt[c] + CNT_W'(1);
        end
      end
    end
  end

  // Latched result bank
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        lat_cnt[c] <= '0;
      end
      lat_ovf <= '0;
    end else if (state == LATCH) begin
      for (int c = 0; c < NUM_CH; c++) begin
        lat_cnt[c] <= cnt[c];
      end
      lat_ovf <= cnt_ovf;
    end
  end

  // Channel select mux; out-of-range reads as zero
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    if (32'(ch_sel) < NUM_CH) begin
      result   = lat_cnt[ch_sel];
      overflow = lat_ovf[ch_sel];
    end
  end

  // Serial readout shift register, load beats shift
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= result;
    end else if (shift) begin
      sreg <= {sreg[CNT_W-2:0], 1'b0};
    end
  end

  assign sout = sreg[CNT_W-1];

endmodule
